cv32e40x_instr_mem_responder: RTL

CV32E40X_INSTR_MEM_RESPONDER -- requirements
Module: cv32e40x_instr_mem_responder

---
 rtl/cv32e40x_pkg.sv | 29 ++
 rtl/cv32e40x_resp_fifo.sv | 63 ++++++
 rtl/cv32e40x_instr_mem_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the instruction-side memory responder: the core's fetch
// response view and the per-transaction entry held while a response is delayed.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        MPU_OK       = 2'b00,
        MPU_RE_FAULT = 2'b01,
        MPU_WR_FAULT = 2'b10
    } mpu_status_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_inst_resp_t;

    typedef struct packed {
        obi_inst_resp_t bus_resp;
        mpu_status_e    mpu_status;
    } inst_resp_t;

    localparam int TIMER_W = 4;

    typedef struct packed {
        logic [31:0]        rdata;
        logic               err;
        logic [TIMER_W-1:0] timer;
    } instr_resp_entry_t;

endpackage

// File: rtl/cv32e40x_resp_fifo.sv
// In-order response FIFO whose entries each carry a countdown timer that
// ages every cycle; the head is always slot 0 and pops shift the queue down.
module cv32e40x_resp_fifo
    import cv32e40x_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = instr_resp_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   not_empty
);

    localparam int CW = $clog2(DEPTH + 1);

    entry_t        slots      [DEPTH];
    entry_t        slots_next [DEPTH];
    entry_t        aged       [DEPTH];
    logic [CW-1:0] count;
    int            wr_idx;

    always_comb begin
        wr_idx = int'(count) - (pop ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            aged[i] = slots[i];
            if (slots[i].timer != '0) begin
                aged[i].timer = slots[i].timer - TIMER_W'(1);
            end
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            slots_next[i] = pop ? aged[i+1] : aged[i];
        end
        slots_next[DEPTH-1] = aged[DEPTH-1];
        // A freshly pushed entry starts at its full delay; it ages from the next cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (i == wr_idx)) begin
                slots_next[i] = push_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            count <= count + CW'(push) - CW'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= slots_next[i];
            end
        end
    end

    assign head      = slots[0];
    assign not_empty = (count != '0);

endmodule

// File: rtl/cv32e40x_instr_mem_responder.sv
// Instruction fetch responder in front of an external synchronous SRAM, with
// per-request response delay and a bounded number of outstanding fetches.
module cv32e40x_instr_mem_responder
    import cv32e40x_pkg::*;
#(
    parameter  int MEM_WORDS   = 1024,
    parameter  int MAX_OUTSTND = 2,
    localparam int AW          = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trans_valid_i,
    output logic          trans_ready_o,
    input  logic [31:0]   trans_addr_i,
    input  logic [3:0]    delay_i,
    output logic          resp_valid_o,
    output inst_resp_t    resp_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i,
    output logic [2:0]    outstnd_cnt_o
);

    logic               init_done;
    logic [2:0]         cnt;
    logic               pend_valid;
    logic               pend_in_range;
    logic [TIMER_W-1:0] pend_delay;
    logic               accept;
    logic               in_range;
    logic               fifo_not_empty;
    logic               resp_valid;
    instr_resp_entry_t  head;
    instr_resp_entry_t  push_entry;
    logic               unused_addr_lsb;

    // Byte-lane bits are irrelevant for word fetches.
    assign unused_addr_lsb = ^trans_addr_i[1:0];

    assign resp_valid    = fifo_not_empty && (head.timer == '0);
    // A response in this cycle frees a slot, so a full responder may still accept.
    assign trans_ready_o = init_done && ((cnt < 3'(MAX_OUTSTND)) || resp_valid);
    assign accept        = trans_valid_i && trans_ready_o;
    assign in_range      = ((trans_addr_i >> (AW + 2)) == 32'd0);
    assign mem_req_o     = accept && in_range;
    assign mem_addr_o    = trans_addr_i[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done     <= 1'b0;
            cnt           <= '0;
            pend_valid    <= 1'b0;
            pend_in_range <= 1'b0;
            pend_delay    <= '0;
        end else begin
            init_done     <= 1'b1;
            cnt           <= cnt + 3'(accept) - 3'(resp_valid);
            pend_valid    <= accept;
            pend_in_range <= in_range;
            pend_delay    <= delay_i;
        end
    end

    // SRAM data arrives while the request sits in the pending stage.
    always_comb begin
        push_entry       = '0;
        push_entry.rdata = pend_in_range ? mem_rdata_i : 32'd0;
        push_entry.err   = !pend_in_range;
        push_entry.timer = pend_delay;
    end

    cv32e40x_resp_fifo #(
        .DEPTH   (MAX_OUTSTND),
        .entry_t (instr_resp_entry_t)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (pend_valid),
        .push_entry (push_entry),
        .pop        (resp_valid),
        .head       (head),
        .not_empty  (fifo_not_empty)
    );

    always_comb begin
        resp_o                = '0;
        resp_o.bus_resp.rdata = head.rdata;
        resp_o.bus_resp.err   = head.err;
        resp_o.mpu_status     = MPU_OK;
    end

    assign resp_valid_o  = resp_valid;
    assign outstnd_cnt_o = cnt;

endmodule
